// File: rtl/bch_piso_tx.sv
// Parallel-in/serial-out transmitter for 63-bit BCH(63,51,2) codewords, MSB-index first.
// Define BCH_PISO_SKID_EN to add a one-entry skid buffer for gapless back-to-back frames.
module bch_piso_tx #(
    parameter int N = 63
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold,
    input  logic [0:N-1] ps_in,
    input  logic         load,
    output logic         ready,
    output logic         ps_out,
    output logic         ps_valid,
    output logic         frame_start,
    output logic         frame_last,
    output logic         state_dbg
);
    // Handshake: a word moves when load && ready at a rising edge; ready never depends on load,
    // and the producer keeps ps_in/load stable until it sees ready high.
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic [5:0] LAST = 6'(N - 1);

    state_t       state, state_nxt;
    logic [N-1:0] sreg, sreg_nxt;
    logic [5:0]   cnt, cnt_nxt;
    logic [N-1:0] ps_word;
    logic         accept;
    logic         at_last;

    // Index-for-index copy so ps_in[N-1] lands in sreg[N-1] and goes out first.
    always_comb begin
        ps_word = '0;
        for (int i = 0; i < N; i++) ps_word[i] = ps_in[i];
    end

`ifdef BCH_PISO_SKID_EN
    logic [N-1:0] skid_buf, skid_buf_nxt;
    logic         buf_full, buf_full_nxt;
    assign ready = !buf_full && !hold;
`else
    assign ready = (state == IDLE) && !hold;
`endif

    assign accept      = load && ready;
    assign at_last     = (cnt == LAST);
    assign ps_out      = sreg[N-1];
    assign ps_valid    = (state == SHIFT) && !hold;
    assign frame_start = ps_valid && (cnt == 6'd0);
    assign frame_last  = ps_valid && at_last;
    assign state_dbg   = (state == SHIFT);

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
`ifdef BCH_PISO_SKID_EN
        skid_buf_nxt = skid_buf;
        buf_full_nxt = buf_full;
`endif
        if (!hold) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg_nxt  = ps_word;
                        cnt_nxt   = 6'd0;
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    sreg_nxt = {sreg[N-2:0], 1'b0};
                    cnt_nxt  = cnt + 6'd1;
                    if (at_last) begin
                        cnt_nxt = 6'd0;
`ifdef BCH_PISO_SKID_EN
                        if (buf_full) begin
                            sreg_nxt     = skid_buf;
                            buf_full_nxt = accept;
                            if (accept) skid_buf_nxt = ps_word;
                        end else if (accept) begin
                            // Empty buffer on the wrap cycle: take the new word straight into sreg.
                            sreg_nxt = ps_word;
                        end else begin
                            state_nxt = IDLE;
                        end
`else
                        state_nxt = IDLE;
`endif
                    end
`ifdef BCH_PISO_SKID_EN
                    else if (accept) begin
                        skid_buf_nxt = ps_word;
                        buf_full_nxt = 1'b1;
                    end
`endif
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= 6'd0;
`ifdef BCH_PISO_SKID_EN
            skid_buf <= '0;
            buf_full <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
`ifdef BCH_PISO_SKID_EN
            skid_buf <= skid_buf_nxt;
            buf_full <= buf_full_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_bch_piso_tx.sv
// Bench for bch_piso_tx: directed steps plus random words, checked against a frame-level model
// that tracks bits remaining, buffer occupancy and a queue of accepted words.
module tb_bch_piso_tx;
    localparam int N = 63;
`ifdef BCH_PISO_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         hold;
    logic [0:N-1] ps_in;
    logic         load;
    logic         ready;
    logic         ps_out;
    logic         ps_valid;
    logic         frame_start;
    logic         frame_last;
    logic         state_dbg;

    bch_piso_tx #(.N(N)) dut (
        .clk(clk), .reset(reset), .hold(hold), .ps_in(ps_in), .load(load),
        .ready(ready), .ps_out(ps_out), .ps_valid(ps_valid),
        .frame_start(frame_start), .frame_last(frame_last), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard and model
    logic [N-1:0] exp_q[$];
    int           m_rem = 0;
    bit           m_buf = 1'b0;
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           last_fl_cyc = -100;
    bit           gap_chk = 1'b0;
    bit           accepted;
    logic [N-1:0] rx = '0;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model at the edge.
    task automatic step(input logic ld, input logic [N-1:0] w, input logic hd, input logic rs);
        logic         e_ready, e_valid, e_out;
        logic [N-1:0] front;
        load  = ld;
        hold  = hd;
        reset = rs;
        for (int i = 0; i < N; i++) ps_in[i] = w[i];
        #1;
        front   = (exp_q.size() > 0) ? exp_q[0] : '0;
        e_ready = !hd && (SKID ? !m_buf : (m_rem == 0));
        e_valid = (m_rem > 0) && !hd;
        e_out   = (m_rem > 0) ? front[m_rem-1] : 1'b0;
        chk("ready", N'(ready), N'(e_ready));
        chk("ps_valid", N'(ps_valid), N'(e_valid));
        chk("ps_out", N'(ps_out), N'(e_out));
        chk("frame_start", N'(frame_start), N'(e_valid && m_rem == N));
        chk("frame_last", N'(frame_last), N'(e_valid && m_rem == 1));
        chk("state_dbg", N'(state_dbg), N'(m_rem > 0));
        if (ps_valid) begin
            rx = {rx[N-2:0], ps_out};
            if (frame_last) chk("loopback_word", rx, front);
        end
        if (gap_chk && frame_start) chk("frame_gap", N'(cyc - last_fl_cyc), N'(SKID ? 1 : 2));
        if (frame_last) last_fl_cyc = cyc;
        @(posedge clk);
        accepted = ld && e_ready && !rs;
        if (rs) begin
            m_rem = 0;
            m_buf = 1'b0;
            exp_q.delete();
        end else if (!hd) begin
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) void'(exp_q.pop_front());
            end
            if (accepted) begin
                exp_q.push_back(w);
                if (m_rem == 0) m_rem = N;
                else m_buf = 1'b1;
            end else if (m_rem == 0 && m_buf) begin
                m_rem = N;
                m_buf = 1'b0;
            end
        end
        cyc++;
        #1;
    endtask

    // driver tasks
    task automatic send(input logic [N-1:0] w);
        int n = 0;
        accepted = 1'b0;
        while (!accepted && n < 200) begin
            step(1'b1, w, 1'b0, 1'b0);
            n++;
        end
        chk("send_timeout", N'(accepted), N'(1));
    endtask

    task automatic drain();
        int n = 0;
        while ((m_rem > 0 || m_buf) && n < 300) begin
            step(1'b0, '0, 1'b0, 1'b0);
            n++;
        end
        chk("drain_timeout", N'(m_rem > 0 || m_buf), N'(0));
    endtask

    task automatic run_to_cnt(input int c);
        int n = 0;
        while (m_rem != N - c && n < 100) begin
            step(1'b0, '0, 1'b0, 1'b0);
            n++;
        end
        chk("reach_cnt", N'(m_rem), N'(N - c));
    endtask

    function automatic logic [N-1:0] rand_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[N-1:0];
    endfunction

    initial begin
        logic [N-1:0] w, wa, wb, wc;
        logic [63:0]  t64;
        reset = 1'b1;
        load  = 1'b1;
        hold  = 1'b0;
        ps_in = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then reset together with load: reset wins.
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, rand_word(), 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("idle_after_reset_load", N'(ps_valid), N'(0));

        // Single set bit at index 62: one 1 then 62 zeros.
        w = '0;
        w[N-1] = 1'b1;
        send(w);
        drain();

        // Loopback of alternating pattern.
        t64 = 64'h5555_5555_5555_5555;
        send(t64[N-1:0]);
        drain();

        // Hold for 3 cycles at cnt=10.
        send(rand_word());
        run_to_cnt(10);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        drain();

        // Reset at cnt=30 with load high, then the new word starts fresh.
        send(rand_word());
        run_to_cnt(30);
        w = rand_word();
        step(1'b1, w, 1'b0, 1'b1);
        chk("post_reset_valid", N'(ps_valid), N'(0));
        send(w);
        chk("post_reset_start", N'(frame_start), N'(1));
        drain();

        // Back-to-back A, B, C with load kept high.
        wa = rand_word();
        wb = rand_word();
        wc = rand_word();
        gap_chk = 1'b1;
        send(wa);
        send(wb);
        send(wc);
        drain();
        gap_chk = 1'b0;

        // Random words, random idle time and random hold.
        for (int k = 0; k < 20; k++) begin
            send(rand_word());
            for (int j = 0; j < int'($urandom_range(0, 70)); j++)
                step(1'b0, '0, ($urandom_range(0, 7) == 0), 1'b0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
